// File: rtl/fractal_st_source_pkg.sv
// fractal_pkg: shared constants, pixel entry type and the iteration-code
// palette for the fractal Avalon-ST source stage.
//   R_W/G_W/B_W     RGB565 field widths
//   PIX_W           packed pixel width (16)
//   CODE_W          solver iteration code width (4)
//   DEF_RD_LATENCY  default solver read latency in cycles
//   pix_t           FIFO entry {sop, eop, rgb565}
//   palette()       4-bit code -> RGB565 colour
package fractal_pkg;

    localparam int R_W            = 5;
    localparam int G_W            = 6;
    localparam int B_W            = 5;
    localparam int PIX_W          = R_W + G_W + B_W;
    localparam int CODE_W         = 4;
    localparam int DEF_RD_LATENCY = 2;

    typedef struct packed {
        logic             sop;
        logic             eop;
        logic [PIX_W-1:0] data;
    } pix_t;

    // Low codes ramp green up, high codes ramp green down over a blue base,
    // and 7/8 are the two bright transition colours of the top-level map.
    function automatic logic [PIX_W-1:0] palette(input logic [CODE_W-1:0] code);
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
        logic [2:0]     inv;
        r   = '0;
        g   = '0;
        b   = '0;
        inv = 3'(4'd15 - code);
        if (code <= 4'd6) begin
            g = {code[2:0], 3'b000};
        end else if (code == 4'd7) begin
            g = 6'b111000;
            b = 5'b01000;
        end else if (code == 4'd8) begin
            g = 6'b111000;
            b = 5'b10000;
        end else begin
            g = {inv, 3'b000};
            b = 5'b11000;
        end
        return {r, g, b};
    endfunction

endpackage

// File: rtl/fractal_st_source_if.sv
// fractal_st_source_if: Avalon-ST video bus between the fractal source stage
// and the streaming sink.
//   valid  source has a pixel on the bus
//   ready  sink accepts the pixel this cycle
//   sop    first pixel of a frame
//   eop    last pixel of a frame
//   data   RGB565 pixel
// master = source side, slave = sink side.
interface fractal_st_source_if;
    import fractal_pkg::*;

    logic             valid;
    logic             ready;
    logic             sop;
    logic             eop;
    logic [PIX_W-1:0] data;

    modport master (output valid, sop, eop, data, input ready);
    modport slave  (input valid, sop, eop, data, output ready);

endinterface

// File: rtl/fractal_st_source_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage; the head entry is
// read combinationally from the storage array, so a pushed word is visible
// at rdata the cycle after the push.
//   clock, reset  clock and synchronous active-high reset
//   push, wdata   write request and data (ignored when full unless popping)
//   pop           read request (ignored when empty)
//   rdata         head entry
//   full, empty   occupancy flags
//   count         number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO can still take a word when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing reads it while count is zero.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fractal_st_source.sv
// fractal_st_source: Avalon-ST video source stage. Issues pixel reads to the
// iterator/solver under credit control, realigns sop/eop/valid with the
// fixed-latency solver data, maps iteration codes to RGB565 and buffers the
// pixels so sink backpressure never drops or duplicates one.
//   clock, reset        system clock, synchronous active-high reset
//   it_en               iterator advance enable (beat accepted when 1)
//   it_start/end/valid  iterator sideband for the current beat
//   rd_data             solver code, valid RD_LATENCY cycles after the beat
//   st                  Avalon-ST source bus (master modport)
//   frame_count         frames delivered to the sink, wrapping
//   overflow            sticky: a push arrived while the FIFO was full
module fractal_st_source
    import fractal_pkg::*;
#(
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int DEPTH      = 4
) (
    input  logic               clock,
    input  logic               reset,
    output logic               it_en,
    input  logic               it_start,
    input  logic               it_end,
    input  logic               it_valid,
    input  logic [CODE_W-1:0]  rd_data,
    fractal_st_source_if.master st,
    output logic [15:0]        frame_count,
    output logic               overflow
);

    localparam int AW = $clog2(DEPTH);
    // Wide enough for fifo_count + inflight without wrapping.
    localparam int CW = $clog2(DEPTH + RD_LATENCY + 1) + 1;

    // Latency pipe: one bit per stage for each sideband field.
    logic [RD_LATENCY-1:0] vld_pipe;
    logic [RD_LATENCY-1:0] sop_pipe;
    logic [RD_LATENCY-1:0] eop_pipe;

    logic [CW-1:0] inflight;
    logic [CW-1:0] credit_used;

    logic          push;
    logic          pop;
    pix_t          push_pix;
    pix_t          head;
    logic          full;
    logic          empty;
    logic [AW:0]   fifo_count;

    // Every valid beat in the pipe already owns a FIFO slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(vld_pipe[i]);
        end
    end

    assign credit_used = CW'(fifo_count) + inflight;
    // Registered state only: no path from st.ready into the iterator.
    assign it_en       = !reset && (credit_used < CW'(DEPTH));

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_pipe <= '0;
            sop_pipe <= '0;
            eop_pipe <= '0;
        end else begin
            // Stage 0 gets a bubble whenever the iterator is held.
            vld_pipe[0] <= it_valid && it_en;
            sop_pipe[0] <= it_start;
            eop_pipe[0] <= it_end;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                sop_pipe[i] <= sop_pipe[i-1];
                eop_pipe[i] <= eop_pipe[i-1];
            end
        end
    end

    // The last pipe stage lines up with the solver data for the same beat.
    assign push          = vld_pipe[RD_LATENCY-1];
    assign push_pix.sop  = sop_pipe[RD_LATENCY-1];
    assign push_pix.eop  = eop_pipe[RD_LATENCY-1];
    assign push_pix.data = palette(rd_data);

    sync_fifo #(
        .WIDTH ($bits(pix_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (push_pix),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // Valid is masked by reset so the bus goes quiet in the reset cycle itself;
    // sideband/data are zeroed whenever nothing is offered.
    assign st.valid = !empty && !reset;
    assign st.sop   = st.valid ? head.sop  : 1'b0;
    assign st.eop   = st.valid ? head.eop  : 1'b0;
    assign st.data  = st.valid ? head.data : '0;
    assign pop      = st.valid && st.ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_count <= '0;
        end else if (pop && head.eop) begin
            frame_count <= frame_count + 16'd1;
        end
    end

    // Only reachable if the credit rule is broken; the push itself is dropped
    // inside the FIFO.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push && full && !pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fractal_st_source.sv
`timescale 1ns/1ps
module tb_fractal_st_source;
    import fractal_pkg::*;

    localparam int LAT   = DEF_RD_LATENCY;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        it_en;
    logic        it_start = 1'b0;
    logic        it_end   = 1'b0;
    logic        it_valid = 1'b0;
    logic [3:0]  rd_data  = 4'd0;
    logic [15:0] frame_count;
    logic        overflow;

    fractal_st_source_if st_bus ();

    fractal_st_source #(.RD_LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .it_en       (it_en),
        .it_start    (it_start),
        .it_end      (it_end),
        .it_valid    (it_valid),
        .rd_data     (rd_data),
        .st          (st_bus),
        .frame_count (frame_count),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    // Expected pixel: what the sink must see, and the first cycle it may appear.
    typedef struct {
        logic        sop;
        logic        eop;
        logic [15:0] data;
        int          rdy;
    } exp_t;

    exp_t        q[$];
    logic [15:0] fc = 16'd0;
    logic [3:0]  lat_q [LAT-1];
    int n_chk = 0, n_err = 0;
    int pix = 0, frame_len = 64, cyc = 0, code_ctr = 0;
    int vmode = 3, rmode = 0, rst_edges = 0;
    int n_acc = 0, n_pop = 0;
    bit cyc_codes = 1'b0, inited = 1'b0, want_sop = 1'b0;
    bit prev_hold = 1'b0;
    logic [15:0] prev_data = '0, last_data = '0, last_fc = '0;
    logic prev_sop = 1'b0, prev_eop = 1'b0, last_it_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Colour rules written as field arithmetic: value = R*2048 + G*32 + B.
    function automatic logic [15:0] ref_rgb(input int code);
        int g, b;
        if (code <= 6)       begin g = code * 8;        b = 0;  end
        else if (code == 7)  begin g = 56;              b = 8;  end
        else if (code == 8)  begin g = 56;              b = 16; end
        else                 begin g = (15 - code) * 8; b = 24; end
        return 16'(g * 32 + b);
    endfunction

    task automatic drive_inputs();
        case (vmode)
            0:       it_valid = 1'b1;
            1:       it_valid = (cyc % 2 == 0);
            2:       it_valid = 1'($urandom_range(1));
            default: it_valid = 1'b0;
        endcase
        it_start = (pix == 0);
        it_end   = (pix == frame_len - 1);
        case (rmode)
            0:       st_bus.ready = 1'b1;
            1:       st_bus.ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            2:       st_bus.ready = 1'b0;
            default: st_bus.ready = 1'($urandom_range(1));
        endcase
    endtask

    // One clock: drive, sample/check at negedge, then update the model with
    // what the rising edge did.
    task automatic step();
        bit acc, popd, rst_now, exp_valid;
        exp_t e;
        logic [3:0] code;
        drive_inputs();
        @(negedge clock);
        rst_now   = reset;
        exp_valid = !reset && q.size() > 0 && q[0].rdy <= cyc;
        chk("it_en", 32'(it_en), 32'(!reset && q.size() < DEPTH));
        chk("st_valid", 32'(st_bus.valid), 32'(exp_valid));
        if (inited) begin
            chk("frame_count", 32'(frame_count), 32'(fc));
            chk("overflow", 32'(overflow), 32'd0);
        end
        if (reset && rst_edges > 0) begin
            chk("rst_sop", 32'(st_bus.sop), 32'd0);
            chk("rst_eop", 32'(st_bus.eop), 32'd0);
            chk("rst_data", 32'(st_bus.data), 32'd0);
        end
        if (prev_hold && !reset) begin
            chk("hold_valid", 32'(st_bus.valid), 32'd1);
            chk("hold_data", 32'(st_bus.data), 32'(prev_data));
            chk("hold_sop", 32'(st_bus.sop), 32'(prev_sop));
            chk("hold_eop", 32'(st_bus.eop), 32'(prev_eop));
        end
        popd = st_bus.valid && st_bus.ready;
        if (popd && q.size() > 0) begin
            chk("pix_data", 32'(st_bus.data), 32'(q[0].data));
            chk("pix_sop", 32'(st_bus.sop), 32'(q[0].sop));
            chk("pix_eop", 32'(st_bus.eop), 32'(q[0].eop));
            if (want_sop) begin
                chk("post_rst_sop", 32'(st_bus.sop), 32'd1);
                want_sop = 1'b0;
            end
        end
        acc        = it_en && it_valid;
        prev_hold  = st_bus.valid && !st_bus.ready;
        prev_data  = st_bus.data;
        prev_sop   = st_bus.sop;
        prev_eop   = st_bus.eop;
        last_it_en = it_en;
        last_data  = st_bus.data;
        last_fc    = frame_count;
        @(posedge clock);
        #1;
        if (rst_now) begin
            q.delete();
            fc        = 16'd0;
            pix       = 0;
            prev_hold = 1'b0;
            inited    = 1'b1;
            rst_edges++;
            foreach (lat_q[i]) lat_q[i] = 4'd0;
            rd_data = 4'd0;
        end else begin
            if (popd && q.size() > 0) begin
                if (q[0].eop) fc = fc + 16'd1;
                void'(q.pop_front());
                n_pop++;
            end
            code = 4'd0;
            if (acc) begin
                code  = cyc_codes ? 4'(code_ctr) : 4'($urandom_range(15));
                code_ctr++;
                e.sop  = (pix == 0);
                e.eop  = (pix == frame_len - 1);
                e.data = ref_rgb(int'(code));
                e.rdy  = cyc + LAT + 1;
                q.push_back(e);
                pix = (pix + 1) % frame_len;
                n_acc++;
            end
            // Solver model: the code of a beat appears LAT cycles after it.
            rd_data = lat_q[LAT-2];
            for (int i = LAT - 2; i > 0; i--) lat_q[i] = lat_q[i-1];
            lat_q[0] = code;
        end
        cyc++;
    endtask

    task automatic do_reset(input int n);
        reset     = 1'b1;
        rst_edges = 0;
        repeat (n) step();
        reset = 1'b0;
    endtask

    initial begin
        int a0, p0, g, stall_acc;
        logic [15:0] held;
        foreach (lat_q[i]) lat_q[i] = 4'd0;
        st_bus.ready = 1'b0;

        do_reset(3);

        // Free-run: codes cycle 0..15, three 64-pixel frames, sink always ready.
        frame_len = 64; cyc_codes = 1'b1; code_ctr = 0; vmode = 0; rmode = 0;
        a0 = n_acc; p0 = n_pop; g = 0;
        while (n_acc - a0 < 192 && g < 1000) begin step(); g++; end
        vmode = 3;
        repeat (LAT + 3) step();
        chk("freerun_pops", 32'(n_pop - p0), 32'd192);
        chk("freerun_frames", 32'(last_fc), 32'd3);

        // Backpressure 1,0,0,1 with random codes.
        cyc_codes = 1'b0; vmode = 0; rmode = 1;
        repeat (200) step();

        // Long stall mid-line.
        rmode = 0;
        repeat (5) step();
        rmode = 2; a0 = n_acc;
        repeat (10) step();
        held = last_data;
        repeat (40) step();
        stall_acc = n_acc - a0;
        chk("stall_acc_cap", 32'(stall_acc <= DEPTH), 32'd1);
        chk("stall_it_en", 32'(last_it_en), 32'd0);
        chk("stall_head", 32'(last_data), 32'(held));
        rmode = 0;
        repeat (20) step();

        // Bubbles on alternate cycles, random sink.
        vmode = 1; rmode = 3;
        repeat (300) step();

        // Fully random traffic.
        vmode = 2; rmode = 3;
        repeat (500) step();

        // Mid-frame reset with a full FIFO.
        vmode = 0; rmode = 2;
        repeat (10) step();
        do_reset(2);
        want_sop = 1'b1; rmode = 0;
        repeat (20) step();
        chk("post_rst_seen", 32'(want_sop), 32'd0);

        // Wrap: 65536 single-pixel frames.
        do_reset(2);
        frame_len = 1; vmode = 0; rmode = 0;
        a0 = n_acc; p0 = n_pop; g = 0;
        while (n_acc - a0 < 65536 && g < 70000) begin step(); g++; end
        if (g >= 70000) chk("wrap_timeout", 32'd0, 32'd1);
        vmode = 3;
        repeat (LAT + 3) step();
        chk("wrap_pops", 32'(n_pop - p0), 32'd65536);
        chk("wrap_count", 32'(last_fc), 32'd0);
        chk("wrap_idle", 32'(st_bus.valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fractal_st_source.md
# fractal_st_source

Avalon-ST video source stage that sits between the pixel iterator and solver read port on one side and the Qsys video streaming sink on the other. It issues pixel reads under credit control and realigns start/end/valid sideband with the fixed-latency solver read data. It maps each 4-bit iteration code to RGB565 and buffers pixels in a small FIFO, so sink backpressure never drops or duplicates a pixel. It replaces the free-running two-stage sideband delay in the top level.

## Interface
- RD_LATENCY, 2: cycles from an accepted iterator beat to the matching `rd_data` value.
- DEPTH, 4: output FIFO entries, power of two, ≥ RD_LATENCY+1.
- clock  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high.
- it_en  out  1  advance enable to the pixel iterator; a beat is accepted on any cycle with it_en=1.
- it_start, it_end, it_valid  in  1 each  iterator sideband for the current beat.
- rd_data  in  4  solver iteration code, valid RD_LATENCY cycles after the beat.
- st_ready  in  1  sink ready.
- st_valid, st_sop, st_eop  out  1 each  source sideband.
- st_data  out  16  RGB565 pixel.
- frame_count  out  16  frames completed, wrapping.
- overflow  out  1  sticky error flag.

## Operation
- **Credit.** `inflight` is the number of valid beats in the latency pipe. `it_en = !reset && (fifo_count + inflight < DEPTH)`.
- **Latency pipe.** RD_LATENCY-stage shift register of {valid, sop, eop}. Stage 0 is loaded with {it_valid & it_en, it_start, it_end}; a bubble is loaded when it_en=0.
- **Push.** When the last pipe stage is valid, push {sop, eop, palette(rd_data)} into the FIFO.
- **Pop.** When st_valid && st_ready, pop the FIFO.
- **Outputs.** st_valid = !empty; st_sop, st_eop and st_data come from the FIFO head.
- **Palette.** 16-entry fixed map from 4-bit code to RGB565, matching the top-level encoding:
  - 0..6: G = code<<3, R=B=0.
  - 7: G=111000, B=01000.
  - 8: G=111000, B=10000.
  - 9..15: B=11000, G = (15-code)<<3.
- **Simultaneous push and pop.** Count is unchanged; both pointers advance. Pushing into a full FIFO is impossible by the credit rule. If it happens anyway, set `overflow`, drop the push, and clear `overflow` only on reset.
- **Pointer wrap.** Read and write pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- **Frame counter.** frame_count increments on a pop whose eop=1, wrapping at 0xFFFF→0.
- **Reset mid-frame.** The pipe, FIFO, and counters all clear, st_valid drops in the same cycle, and in-flight beats are discarded. The iterator must be reset by the same signal.

## Timing
- Reset values:
  - it_en=0, st_valid=0, st_sop=0, st_eop=0, st_data=0, frame_count=0, overflow=0.
  - FIFO empty, pipe all-invalid.
- it_en rises on the first cycle after reset deasserts.
- Latency from an accepted valid beat at cycle t to st_valid: t+RD_LATENCY+1, if the FIFO was empty. The FIFO is registered, so the head is visible the cycle after the push.
- Sustained throughput is 1 pixel/cycle while st_ready=1. This needs DEPTH ≥ RD_LATENCY+2; the default 4 meets it.
- st_data, st_sop and st_eop are held stable while st_valid=1 and st_ready=0.
- it_en is combinational from registered state only and has no path from st_ready.

## Structure
- Package `fractal_pkg` holds:
  - the PALETTE function or constant array (16×16-bit);
  - the RGB565 field widths;
  - the localparam for the default RD_LATENCY.
- One sub-module, `sync_fifo` (WIDTH=18, DEPTH), with push, pop, full, empty and count outputs. The credit logic, latency pipe and palette stay in the top of this block.

## Test plan
- **Free-run.** st_ready=1, iterator streams 640×480 with codes cycling 0..15 → 307200 beats out, 1/cycle after a 3-cycle fill. st_data follows the map: 0→0x0000, 7→0x0708, 8→0x0710, 15→0x0018. Exactly one sop (first beat) and one eop (last beat); frame_count=1.
- **Backpressure.** st_ready toggles 1,0,0,1 repeating → no pixel lost or duplicated (check by scoreboard order). it_en drops once fifo_count+inflight=4. overflow stays 0.
- **Long stall.** st_ready=0 for 50 cycles mid-line → at most 4 beats accepted, then it_en=0. The head holds stable. Releasing resumes in order.
- **Bubbles.** it_valid=0 on alternate cycles → output contains only valid beats, sop/eop preserved on the correct pixels.
- **Mid-frame reset.** Reset at pixel 1000 with a full FIFO → the next cycle has st_valid=0, frame_count=0, it_en=0. After release, the next output is the sop of a fresh frame.
- **Wrap.** Force frame_count=0xFFFF, complete one frame → 0x0000.
